ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decode stage.
- Holds the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request channel plus a valid response channel.
- Presents {inst, inst_pc} to decode with a valid/ready handshake.
- Accepts redirects (branch/jump target) from execute and discards stale fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PC_STEP, 4, increment applied after each instruction is consumed by decode.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  fetch address; equals current PC.
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, arriving ≥1 cycle after acceptance).
- imem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  instruction word to decode.
- inst_pc  out  32  PC of the presented instruction.
- redirect_valid  in  1  execute requests a PC change (taken branch, jal, jalr).
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0 internally.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=REQ, flush=0.
  - imem_req_valid=0 while in reset; inst_valid=0; inst=0; inst_pc=0.
- States:
  - REQ: drive imem_req_valid=1, imem_addr=pc.
  - WAIT: request accepted, response outstanding.
  - HOLD: instruction registered and presented to decode.
- REQ:
  - redirect_valid → pc=redirect_pc & ~3, stay REQ; the request that cycle still issues with the old pc if imem_req_ready=1, and flush=1 is set; go WAIT.
  - Otherwise, imem_req_ready=1 → WAIT.
- WAIT:
  - imem_rsp_valid with flush=0 and no redirect → latch inst=imem_rsp_data and inst_pc=pc, go HOLD.
  - imem_rsp_valid with flush=1 or redirect_valid → discard data, clear flush, go REQ (pc already or now set to the target).
  - redirect_valid without a response → pc=target, flush=1, stay WAIT.
- HOLD:
  - inst_valid=1; inst and inst_pc stay stable until the handshake.
  - inst_ready=1 → pc=pc+PC_STEP (32-bit wrap), go REQ.
  - redirect_valid → drop the instruction (inst_valid=0 next cycle), pc=target, go REQ.
  - redirect and inst_ready in the same cycle: the handshake completes, redirect wins for the next pc.
- At most one request is outstanding.
- Minimum fetch-to-present latency: request accepted in cycle N, response in N+1, inst_valid in N+2.
- Throughput: one instruction per 3 cycles.
- inst_valid is never asserted for a flushed fetch.
- A redirect never produces a duplicate request for the same accepted fetch.
- Reset asserted mid-WAIT: state returns to REQ. A late response arriving after reset is ignored because state≠WAIT.
- imem_req_valid, once asserted in REQ, stays asserted until imem_req_ready, unless a redirect changes imem_addr (permitted).

Optional Feature:
- IFU_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt[31:0] (count of decode handshakes) and perf_flush_cnt[31:0] (count of discarded responses plus dropped HOLD instructions).
  - Both are reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset release, memory always ready, 1-cycle response of 32'h00000013; inst_ready=1 → first imem_addr=8000_0000; inst_valid with inst_pc=8000_0000, then 8000_0004, 8000_0008 at 3-cycle spacing.
2. Decode stalls (inst_ready=0 for 5 cycles) in HOLD → inst/inst_pc are stable, no new request is issued, pc advances by exactly 4 after release.
3. Redirect to 8000_0100 while in WAIT → the response is discarded (inst_valid stays 0), the next request addr is 8000_0100, and the next inst_pc is 8000_0100.
4. Redirect to 8000_0203 while in HOLD → the held instruction is dropped and the next imem_addr is 8000_0200.
5. imem_req_ready low for 4 cycles → imem_req_valid is held with addr stable, and no response is consumed before acceptance.
6. rst_n pulsed low during WAIT, then a late imem_rsp_valid → ignored; fetch restarts at RESET_PC. With IFU_PERF_CNT_EN, after scenario 3, perf_flush_cnt=1.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request, decode hand-off, redirect/flush.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_pc_q;
  logic        flush_q, flush_d;
  logic        latch;
  logic        discard;
  logic        drop;
  logic [31:0] redirect_tgt;

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    latch   = 1'b0;
    discard = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) pc_d = redirect_tgt;
        // A request accepted alongside a redirect carries the old pc and must be flushed.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          flush_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (flush_q || redirect_valid) begin
            discard = 1'b1;
            flush_d = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redirect_tgt;
          end else begin
            latch   = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = redirect_tgt;
          flush_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
          drop    = !inst_ready;
        end else if (inst_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      flush_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      if (latch) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc_q;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state_q == S_HOLD && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (discard || drop) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: program-order PC model plus a single-outstanding memory model.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Reference model: next PC decode must see, and the memory's one pending fetch.
  logic [31:0] exp_pc = RESET_PC;
  bit          outstanding = 0;
  int          rsp_cnt = 0;
  logic [31:0] out_addr = '0;
  int          delivered = 0, handshakes = 0;
  int          cyc = 0, last_hs_cyc = -1, acc_cyc = 0;
  bit          prev_req_stall = 0, prev_hold_stall = 0;
  logic [31:0] prev_addr = '0, prev_inst = '0, prev_inst_pc = '0;
  bit          last_accept = 0, last_valid = 0;

  int          p_rdy = 100, p_irdy = 100, p_redir = 0, max_dly = 0;
  bit          chk_spacing = 1;
  bit          force_redir = 0;
  logic [31:0] force_tgt = '0;

  task automatic clear_history();
    prev_req_stall  = 0;
    prev_hold_stall = 0;
    last_hs_cyc     = -1;
  endtask

  task automatic do_cycle();
    @(negedge clk);
    if (prev_req_stall) begin
      check32("req_held", 32'(imem_req_valid), 32'd1);
      check32("req_addr_stable", imem_addr, prev_addr);
    end
    if (prev_hold_stall) begin
      check32("hold_valid", 32'(inst_valid), 32'd1);
      check32("hold_inst", inst, prev_inst);
      check32("hold_pc", inst_pc, prev_inst_pc);
    end
    if (inst_valid) check32("no_req_in_hold", 32'(imem_req_valid), 32'd0);
`ifdef IFU_PERF_CNT_EN
    check32("perf_fetch", perf_fetch_cnt, 32'(handshakes));
    check32("perf_flush", perf_flush_cnt, 32'(delivered - handshakes - int'(inst_valid)));
`endif
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    inst_ready     = ($urandom_range(0, 99) < p_irdy);
    redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir);
    redirect_pc    = force_redir ? force_tgt : RESET_PC + 32'($urandom_range(0, 4095));
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (outstanding) begin
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(out_addr);
        outstanding    = 0;
        delivered++;
      end else begin
        rsp_cnt--;
      end
    end
    #1;
    last_accept = imem_req_valid && imem_req_ready;
    last_valid  = inst_valid;
    if (last_accept) begin
      check32("single_outstanding", 32'(outstanding), 32'd0);
      check32("fetch_addr", imem_addr, exp_pc);
      outstanding = 1;
      out_addr    = imem_addr;
      rsp_cnt     = $urandom_range(0, max_dly);
      acc_cyc     = cyc;
    end
    if (inst_valid && inst_ready) begin
      check32("inst_pc", inst_pc, exp_pc);
      check32("inst", inst, mem_word(exp_pc));
      if (chk_spacing) begin
        if (last_hs_cyc >= 0) check32("throughput", 32'(cyc - last_hs_cyc), 32'd3);
        check32("latency", 32'(cyc - acc_cyc), 32'd2);
      end
      last_hs_cyc = cyc;
      handshakes++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    prev_req_stall  = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_hold_stall = inst_valid && !inst_ready && !redirect_valid;
    prev_addr       = imem_addr;
    prev_inst       = inst;
    prev_inst_pc    = inst_pc;
    cyc++;
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_inst_valid", 32'(inst_valid), 32'd0);
    check32("rst_inst", inst, 32'd0);
    check32("rst_inst_pc", inst_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with ideal memory and decode: fixed latency and 3-cycle spacing.
    repeat (12) do_cycle();
    chk_spacing = 0;

    // Decode stall in HOLD.
    p_irdy = 0;
    repeat (6) do_cycle();
    p_irdy = 100;
    repeat (6) do_cycle();

    // Redirect while a response is outstanding.
    max_dly = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle();
      found = last_accept;
    end
    check32("reach_wait", 32'(found), 32'd1);
    force_redir = 1; force_tgt = 32'h8000_0100;
    do_cycle();
    force_redir = 0;
    repeat (8) do_cycle();

    // Redirect with an unaligned target while an instruction is held.
    p_irdy = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle();
      found = last_valid;
    end
    check32("reach_hold", 32'(found), 32'd1);
    force_redir = 1; force_tgt = 32'h8000_0203;
    do_cycle();
    force_redir = 0;
    @(posedge clk); #1;
    check32("drop_valid", 32'(inst_valid), 32'd0);
    check32("drop_req", 32'(imem_req_valid), 32'd1);
    check32("drop_addr", imem_addr, 32'h8000_0200);
    p_irdy = 100;

    // Memory back-pressure.
    p_rdy = 0;
    repeat (5) do_cycle();
    p_rdy = 100;
    repeat (6) do_cycle();

    // Randomized mix.
    p_rdy = 70; p_irdy = 70; p_redir = 10; max_dly = 3;
    repeat (1500) do_cycle();
    check32("progress", 32'(handshakes >= 100), 32'd1);

    // Reset during WAIT, then a late response that must be ignored.
    p_redir = 0; p_rdy = 100;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle();
      found = last_accept;
    end
    check32("reach_wait2", 32'(found), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check32("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst2_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    outstanding = 0; exp_pc = RESET_PC; delivered = 0; handshakes = 0;
    clear_history();
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    check32("late_addr", imem_addr, RESET_PC);
    @(posedge clk); #1;
    check32("late_ignored", 32'(inst_valid), 32'd0);
    check32("restart_req", 32'(imem_req_valid), 32'd1);
    imem_rsp_valid = 1'b0;
    p_rdy = 80; p_irdy = 80; max_dly = 1;
    repeat (40) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
